reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
Parametrised reaction-time game controller. It is the successor to the two-state start latch.
- A start press arms a pseudo-random wait, then lights the GO LED and counts ticks until the player presses stop.
- It reports the reaction count, flags a false start if stop is pressed before GO, and saturates on timeout.
- It sits between the debounced button inputs and the display/LED drivers.

Parameters:
CNT_W, 16, width of the reaction-count result in ticks
DELAY_W, 8, number of LFSR bits used for the random part of the wait (1..16)
MIN_DELAY, 16, fixed minimum wait in ticks (must be >= 1)
TICK_DIV, 50000, clock cycles per tick (must be >= 2)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  debounced start button (level)
stop  input  1  debounced player button (level)
led  output  1  GO light; high only in GO state
result  output  CNT_W  latched reaction count in ticks
result_valid  output  1  high in DONE state
false_start  output  1  high in FOUL state
busy  output  1  high in WAIT or GO

Behaviour:
- Reset: synchronous, active-high, one clock. state=IDLE, led=0, result=0, result_valid=0, false_start=0, busy=0, tick counter=0, edge-detect registers=0, LFSR=16'hACE1. Reset overrides everything, including mid-round.
- Edge detect: registered copies start_q and stop_q. start_ev = start & ~start_q; stop_ev = stop & ~stop_q. Holding a button yields exactly one event.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, advances every clock (including IDLE). Never reaches zero.
- Tick generator: counter 0..TICK_DIV-1. tick=1 on the cycle the counter equals TICK_DIV-1; counter then wraps to 0. Counter is cleared to 0 on entry to WAIT and on entry to GO, so the first tick after entry occurs TICK_DIV clocks later.
- All outputs are registered and derived from next state. They change on the clock edge that enters the state.
- IDLE: start_ev -> WAIT. Load delay = MIN_DELAY + lfsr[DELAY_W-1:0]. stop_ev is ignored.
- WAIT (busy=1):
  - Decrement delay on tick; when tick and delay==1 -> GO.
  - stop_ev -> FOUL (false_start=1). stop_ev wins over simultaneous expiry.
  - start_ev is ignored.
- GO (busy=1, led=1):
  - Count register cleared on entry; increments on each tick, saturating at 2^CNT_W-1.
  - stop_ev -> DONE with result = count register value (pre-increment if tick coincides). stop on the first GO cycle gives result=0.
  - If count is at max and tick occurs -> DONE with result = all-ones (timeout).
- DONE (result_valid=1) / FOUL (false_start=1):
  - Outputs and result hold stable.
  - start_ev -> WAIT: result_valid and false_start clear on that edge. result keeps its old value until overwritten at the next DONE.
  - FOUL leaves result unchanged.
  - stop_ev is ignored.
- Simultaneous start_ev and stop_ev: each state uses only the event it listens to, as listed above.
- WAIT length: exactly TICK_DIV*(MIN_DELAY+r) clocks from the WAIT-entry edge to the GO-entry edge, where r = sampled LFSR bits.

Test Plan:
(bench parameters TICK_DIV=4, MIN_DELAY=2, DELAY_W=2, CNT_W=4)
1. Reset, pulse start 1 cycle -> busy=1 next edge; led rises 4*(2+r) clocks later, r = bits[1:0] of the model LFSR at sample time, range 8..20 clocks.
2. After led rise, assert stop 10 clocks later -> DONE, result=2, result_valid=1, led=0, busy=0. Holding stop high produces no further change.
3. Assert stop 3 clocks into WAIT -> false_start=1, led never rises, result unchanged. Then start -> false_start=0, busy=1.
4. Never press stop in GO -> after 4*15 clocks count=15; next tick -> DONE, result=4'hF.
5. stop_ev on the same cycle as the final WAIT tick -> FOUL, not GO. Hold start high across a whole round -> only one round is armed.
6. Assert reset during GO with led=1 -> next edge: IDLE, all outputs 0. The subsequent start arms normally.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random wait, GO light, tick-counted reaction.
// Reports the reaction count, flags false starts and saturates on timeout.
module reaction_timer #(
    parameter int CNT_W     = 16,
    parameter int DELAY_W   = 8,
    parameter int MIN_DELAY = 16,
    parameter int TICK_DIV  = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             led,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             false_start,
    output logic             busy
);

    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_DONE,
        S_FOUL
    } state_t;

    state_t           state, state_n;
    logic             start_q, stop_q;
    logic             start_ev, stop_ev;
    logic             tick, tclr;
    logic [15:0]      lfsr;
    logic [TW-1:0]    tcnt;
    logic [31:0]      delay, delay_n, delay_load;
    logic [CNT_W-1:0] count, count_n, result_n;

    assign start_ev   = start & ~start_q;
    assign stop_ev    = stop & ~stop_q;
    assign tick       = (tcnt == TW'(TICK_DIV - 1));
    assign delay_load = 32'(MIN_DELAY) + 32'(lfsr[DELAY_W-1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            lfsr         <= 16'hACE1;
            tcnt         <= '0;
            delay        <= '0;
            count        <= '0;
            result       <= '0;
            led          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
        end else begin
            state        <= state_n;
            start_q      <= start;
            stop_q       <= stop;
            lfsr         <= {lfsr[14:0],
                             lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tcnt         <= (tclr || tick) ? '0 : tcnt + TW'(1);
            delay        <= delay_n;
            count        <= count_n;
            result       <= result_n;
            // Outputs follow the state being entered on this edge
            led          <= (state_n == S_GO);
            busy         <= (state_n == S_WAIT) || (state_n == S_GO);
            result_valid <= (state_n == S_DONE);
            false_start  <= (state_n == S_FOUL);
        end
    end

    always_comb begin
        state_n  = state;
        delay_n  = delay;
        count_n  = count;
        result_n = result;
        tclr     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start_ev) begin
                    state_n = S_WAIT;
                    delay_n = delay_load;
                    tclr    = 1'b1;
                end
            end
            S_WAIT: begin
                // A stop press beats a wait expiring on the same cycle
                if (stop_ev) begin
                    state_n = S_FOUL;
                end else if (tick) begin
                    if (delay == 32'd1) begin
                        state_n = S_GO;
                        count_n = '0;
                        tclr    = 1'b1;
                    end else begin
                        delay_n = delay - 32'd1;
                    end
                end
            end
            S_GO: begin
                if (stop_ev) begin
                    state_n  = S_DONE;
                    result_n = count;
                end else if (tick) begin
                    if (count == '1) begin
                        state_n  = S_DONE;
                        result_n = '1;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed rounds plus random button activity,
// compared every cycle against a timestamp-based model of the game.
module tb_reaction_timer;

    localparam int CW = 4;
    localparam int DW = 2;
    localparam int MD = 2;
    localparam int TD = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_GO   = 2;
    localparam int P_DONE = 3;
    localparam int P_FOUL = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          led;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          false_start;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          ph     = P_IDLE;
    int          go_at  = 0;
    int          m_res  = 0;
    int          last_r = 0;
    logic [15:0] ml     = 16'hACE1;
    logic        msq    = 1'b0;
    logic        mpq    = 1'b0;

    reaction_timer #(
        .CNT_W    (CW),
        .DELAY_W  (DW),
        .MIN_DELAY(MD),
        .TICK_DIV (TD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .led         (led),
        .result      (result),
        .result_valid(result_valid),
        .false_start (false_start),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Game rules in terms of absolute edge numbers: GO lands at a fixed
    // edge, and the reaction count is elapsed whole ticks since GO.
    task automatic model(input logic s, input logic p, input logic r);
        logic sev, pev;
        int   el;
        if (r) begin
            ph    = P_IDLE;
            m_res = 0;
            ml    = 16'hACE1;
            msq   = 1'b0;
            mpq   = 1'b0;
        end else begin
            sev = s && !msq;
            pev = p && !mpq;
            case (ph)
                P_IDLE, P_DONE, P_FOUL: begin
                    if (sev) begin
                        last_r = int'(ml[DW-1:0]);
                        go_at  = cyc + TD * (MD + last_r);
                        ph     = P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (pev) ph = P_FOUL;
                    else if (cyc == go_at) ph = P_GO;
                end
                P_GO: begin
                    el = (cyc - go_at - 1) / TD;
                    if (pev) begin
                        ph    = P_DONE;
                        m_res = (el > CMAX) ? CMAX : el;
                    end else if (cyc == go_at + TD * (CMAX + 1)) begin
                        ph    = P_DONE;
                        m_res = CMAX;
                    end
                end
                default: ;
            endcase
            ml  = lfsr_next(ml);
            msq = s;
            mpq = p;
        end
    endtask

    task automatic step(input logic s, input logic p, input logic r);
        start = s;
        stop  = p;
        reset = r;
        @(posedge clock);
        cyc++;
        model(s, p, r);
        #1;
        check("led", int'(led), int'(ph == P_GO));
        check("busy", int'(busy), int'(ph == P_WAIT || ph == P_GO));
        check("result_valid", int'(result_valid), int'(ph == P_DONE));
        check("false_start", int'(false_start), int'(ph == P_FOUL));
        check("result", int'(result), m_res);
    endtask

    task automatic wait_led(input logic s, input string tag, output int n);
        n = 0;
        while (!led && n < 64) begin
            step(s, 1'b0, 1'b0);
            n++;
        end
        check(tag, int'(led), 1);
    endtask

    initial begin
        int  n;
        int  arm_r;
        logic rs, rp;

        // 1: reset, then arm and measure the random wait
        step(0, 0, 1);
        step(0, 0, 1);
        check("rst_led", int'(led), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        step(1, 0, 0);
        arm_r = last_r;
        check("t1_busy", int'(busy), 1);
        wait_led(0, "t1_led_rise", n);
        check("t1_wait_len", n, TD * (MD + arm_r));

        // 2: stop ten clocks after GO, then hold it
        repeat (10) step(0, 0, 0);
        step(0, 1, 0);
        check("t2_result", int'(result), 2);
        check("t2_valid", int'(result_valid), 1);
        check("t2_led", int'(led), 0);
        repeat (6) step(0, 1, 0);
        check("t2_hold_result", int'(result), 2);
        check("t2_hold_busy", int'(busy), 0);

        // 3: false start three clocks into the wait
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        check("t3_foul", int'(false_start), 1);
        check("t3_result", int'(result), 2);
        repeat (25) step(0, 1, 0);
        check("t3_no_led", int'(led), 0);
        step(1, 0, 0);
        check("t3_rearm_fs", int'(false_start), 0);
        check("t3_rearm_busy", int'(busy), 1);

        // 4: never stop -> saturating timeout
        wait_led(0, "t4_led_rise", n);
        n = 0;
        while (!result_valid && n < 100) begin
            step(0, 0, 0);
            n++;
        end
        check("t4_go_len", n, TD * (CMAX + 1));
        check("t4_result", int'(result), CMAX);
        check("t4_valid", int'(result_valid), 1);

        // 5: stop on the same edge as the wait expiring
        step(1, 0, 0);
        n = 0;
        while (cyc < go_at - 1 && n < 64) begin
            step(0, 0, 0);
            n++;
        end
        check("t5_reach_edge", int'(cyc == go_at - 1), 1);
        step(0, 1, 0);
        check("t5_foul", int'(false_start), 1);
        check("t5_led", int'(led), 0);
        check("t5_result", int'(result), CMAX);

        // 5b: start held through a whole round arms only once
        step(1, 0, 0);
        wait_led(1, "t5b_led_rise", n);
        repeat (5) step(1, 0, 0);
        step(1, 1, 0);
        check("t5b_result", int'(result), 1);
        repeat (12) step(1, 0, 0);
        check("t5b_one_round", int'(busy), 0);
        check("t5b_valid", int'(result_valid), 1);
        step(0, 0, 0);

        // 6: reset in the middle of GO
        step(1, 0, 0);
        step(0, 0, 0);
        wait_led(0, "t6_led_rise", n);
        step(0, 0, 0);
        step(0, 0, 1);
        check("t6_led", int'(led), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_result", int'(result), 0);
        step(1, 0, 0);
        check("t6_rearm", int'(busy), 1);
        wait_led(0, "t6_led_again", n);
        step(0, 1, 0);
        check("t6_done", int'(result_valid), 1);

        // Random button levels with occasional reset
        rs = 1'b0;
        rp = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) rs = ~rs;
            if ($urandom_range(0, 7) == 0) rp = ~rp;
            step(rs, rp, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
